// File: rtl/bus_scratchpad_slave_pkg.sv
// bus_scratchpad_slave_pkg: FSM encoding and window-mask helper; SCRATCH_SLAVE_BOUNDARY_ERROR_EN adds ERROR_END
package bus_scratchpad_slave_pkg;
  typedef enum logic [2:0] {
    IDLE, READ_SETUP, READ_BURST, READ_END, WRITE_BURST
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
    , ERROR_END
`endif
  } state_t;
  function automatic logic [31:0] win_mask(input int ab);
    return 32'hFFFF_FFFF << (ab + 2);
  endfunction
endpackage

// File: rtl/bus_scratchpad_slave_ram.sv
// scratchpad_ram: single-port 32-bit RAM with byte write enables and a registered, zero-idle read
module scratchpad_ram #(
  parameter int addressBits = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [addressBits-1:0] addr,
  input  logic                   rd,
  input  logic [3:0]             we,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata
);
  logic [31:0] mem [2**addressBits];
  // byte-masked write; contents survive reset
  always_ff @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  // read register feeds the OR-combined bus directly, so it returns to zero when not reading
  always_ff @(posedge clock)
    rdata <= (reset || !rd) ? '0 : mem[addr];
endmodule

// File: rtl/bus_scratchpad_slave.sv
// bus_scratchpad_slave: word-addressed scratchpad bus responder; SCRATCH_SLAVE_BOUNDARY_ERROR_EN rejects bursts past the last word
module bus_scratchpad_slave
  import bus_scratchpad_slave_pkg::*;
#(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          addressBits = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);
  localparam logic [31:0] MASK = win_mask(addressBits);
  logic beg_r, rnw_r, end_r, dv_r;
  logic [31:0] ad_r;
  logic [7:0] bs_r;
  logic [3:0] be_r, bel, bel_n;
  state_t state, state_n;
  logic [addressBits-1:0] idx, idx_n;
  logic [8:0] cnt, cnt_n;
  logic dv_n, end_n, rd, wr, hit;
  assign hit = beg_r && ((ad_r & MASK) == (baseAddress & MASK));
  assign busyOut = 1'b0;
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
  logic over, blk, blk_n, err_n;
  assign over = (32'(ad_r[addressBits+1:2]) + 32'(bs_r)) > 32'(2**addressBits - 1);
`else
  assign busErrorOut = 1'b0;
`endif
  // register every bus input once on entry
  always_ff @(posedge clock)
    if (reset) begin
      beg_r <= 1'b0;
      rnw_r <= 1'b0;
      end_r <= 1'b0;
      dv_r  <= 1'b0;
      ad_r  <= '0;
      bs_r  <= '0;
      be_r  <= '0;
    end else begin
      beg_r <= beginTransactionIn;
      rnw_r <= readNotWriteIn;
      end_r <= endTransactionIn;
      dv_r  <= dataValidIn;
      ad_r  <= addressDataIn;
      bs_r  <= burstSizeIn;
      be_r  <= byteEnablesIn;
    end
  // FSM state, burst bookkeeping and registered handshake outputs
  always_ff @(posedge clock)
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      cnt               <= '0;
      bel               <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
      blk               <= 1'b0;
      busErrorOut       <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      cnt               <= cnt_n;
      bel               <= bel_n;
      dataValidOut      <= dv_n;
      endTransactionOut <= end_n;
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
      blk               <= blk_n;
      busErrorOut       <= err_n;
`endif
    end
  // next-state and RAM control; read data lags the RAM address by one cycle
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    bel_n   = bel;
    dv_n    = 1'b0;
    end_n   = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
    blk_n   = blk;
    err_n   = 1'b0;
`endif
    case (state)
      IDLE:
        if (hit) begin
          idx_n   = ad_r[addressBits+1:2];
          cnt_n   = {1'b0, bs_r};
          bel_n   = be_r;
          state_n = rnw_r ? READ_SETUP : WRITE_BURST;
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
          blk_n   = over && !rnw_r;
          if (over) begin
            state_n = ERROR_END;
            err_n   = 1'b1;
            end_n   = 1'b1;
          end
`endif
        end
      READ_SETUP: begin
        rd      = 1'b1;
        dv_n    = 1'b1;
        idx_n   = idx + addressBits'(1);
        state_n = READ_BURST;
      end
      READ_BURST:
        if (cnt == 9'd0) begin
          end_n   = 1'b1;
          state_n = READ_END;
        end else begin
          rd    = 1'b1;
          dv_n  = 1'b1;
          idx_n = idx + addressBits'(1);
          cnt_n = cnt - 9'd1;
        end
      READ_END: state_n = IDLE;
      WRITE_BURST: begin
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
        wr      = dv_r && !blk;
        blk_n   = blk && !end_r;
`else
        wr      = dv_r;
`endif
        idx_n   = dv_r ? idx + addressBits'(1) : idx;
        state_n = end_r ? IDLE : WRITE_BURST;
      end
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
      ERROR_END: begin
        blk_n   = blk && !end_r;
        state_n = (blk && !end_r) ? WRITE_BURST : IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  scratchpad_ram #(.addressBits(addressBits)) u_ram (
    .clock (clock),
    .reset (reset),
    .addr  (idx),
    .rd    (rd),
    .we    (wr ? bel : 4'h0),
    .wdata (ad_r),
    .rdata (addressDataOut)
  );
endmodule

// File: tb/tb_bus_scratchpad_slave.sv
// tb_bus_scratchpad_slave: directed self-checking bench for bus_scratchpad_slave
module tb_bus_scratchpad_slave;
  logic clock = 1'b0, reset = 1'b1;
  logic begin_t = 1'b0, rnw_t = 1'b0, end_t = 1'b0, dv_t = 1'b0;
  logic [31:0] ad_in = '0;
  logic [7:0] bs_t = '0;
  logic [3:0] be_t = '0;
  logic [31:0] ad_out;
  logic dv_out, end_out, busy_out, err_out;
  logic [31:0] exp_w [0:15];
  logic [31:0] wr_w [0:15];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  bus_scratchpad_slave dut (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (begin_t),
    .addressDataIn      (ad_in),
    .readNotWriteIn     (rnw_t),
    .burstSizeIn        (bs_t),
    .byteEnablesIn      (be_t),
    .endTransactionIn   (end_t),
    .dataValidIn        (dv_t),
    .addressDataOut     (ad_out),
    .dataValidOut       (dv_out),
    .endTransactionOut  (end_out),
    .busyOut            (busy_out),
    .busErrorOut        (err_out)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic begin_tx(input logic [31:0] a, input logic rnw, input logic [7:0] bs, input logic [3:0] be);
    @(posedge clock); #1;
    begin_t = 1'b1; ad_in = a; rnw_t = rnw; bs_t = bs; be_t = be;
    @(posedge clock); #1;
    begin_t = 1'b0; ad_in = '0; rnw_t = 1'b0; bs_t = '0; be_t = '0;
  endtask
  task automatic do_write(input logic [31:0] a, input int n, input logic [3:0] be);
    begin_tx(a, 1'b0, 8'(n - 1), be);
    for (int i = 0; i < n; i++) begin
      dv_t = 1'b1; ad_in = wr_w[i]; end_t = (i == n - 1);
      @(posedge clock); #1;
    end
    dv_t = 1'b0; ad_in = '0; end_t = 1'b0;
    repeat (2) @(posedge clock);
  endtask
  task automatic do_read(input string tag, input logic [31:0] a, input int burst);
    begin_tx(a, 1'b1, 8'(burst), 4'hF);
    for (int c = 1; c <= burst + 6; c++) begin
      logic e_dv, e_end;
      logic [31:0] e_d;
      @(negedge clock);
      e_dv = (c >= 3) && (c <= 3 + burst);
      e_end = (c == 4 + burst);
      e_d = '0;
      if (e_dv) e_d = exp_w[c - 3];
      chk($sformatf("%s cyc%0d", tag, c), {err_out, busy_out, end_out, dv_out, ad_out},
          {1'b0, 1'b0, e_end, e_dv, e_d});
      @(posedge clock);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset", {err_out, busy_out, end_out, dv_out, ad_out}, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    wr_w[0] = 32'hDEADBEEF;
    do_write(32'h5000_0010, 1, 4'hF);
    exp_w[0] = 32'hDEADBEEF;
    do_read("single", 32'h5000_0010, 0);
    wr_w[0] = 32'h11223344;
    do_write(32'h5000_0020, 1, 4'hF);
    wr_w[0] = 32'hAABBCCDD;
    do_write(32'h5000_0020, 1, 4'b0101);
    exp_w[0] = 32'h11BB33DD;
    do_read("byte_en", 32'h5000_0020, 0);
    for (int i = 0; i < 16; i++) begin
      wr_w[i] = 32'(i);
      exp_w[i] = 32'(i);
    end
    do_write(32'h5000_0100, 16, 4'hF);
    do_read("burst", 32'h5000_0100, 15);
    begin_tx(32'h4000_0000, 1'b1, 8'd0, 4'hF);
    repeat (20) begin
      @(negedge clock);
      chk("miss", {err_out, busy_out, end_out, dv_out, ad_out}, '0);
    end
`ifdef SCRATCH_SLAVE_BOUNDARY_ERROR_EN
    exp_w[0] = 32'hDEADBEEF;
    begin_tx(32'h5000_07F8, 1'b1, 8'd3, 4'hF);
    @(negedge clock);
    chk("bound pre", {err_out, end_out, dv_out}, 3'b000);
    @(posedge clock); @(negedge clock);
    chk("bound err", {err_out, end_out, dv_out}, 3'b110);
    @(posedge clock); @(negedge clock);
    chk("bound post", {err_out, end_out, dv_out}, 3'b000);
    do_read("bound keep", 32'h5000_0010, 0);
`else
    for (int i = 0; i < 4; i++) begin
      wr_w[i] = 32'hA0 + 32'(i);
      exp_w[i] = 32'hA0 + 32'(i);
    end
    do_write(32'h5000_07F8, 4, 4'hF);
    do_read("wrap", 32'h5000_07F8, 3);
    exp_w[0] = 32'hA2;
    do_read("wrap w0", 32'h5000_0000, 0);
    exp_w[0] = 32'hA3;
    do_read("wrap w1", 32'h5000_0004, 0);
`endif
    begin_tx(32'h5000_0100, 1'b1, 8'd7, 4'hF);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst beat3", {end_out, dv_out, ad_out}, {1'b0, 1'b1, 32'd2});
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst zero", {err_out, busy_out, end_out, dv_out, ad_out}, '0);
    end
    exp_w[0] = 32'hDEADBEEF;
    do_read("after rst", 32'h5000_0010, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
